// File: rtl/sga_pkg.sv
// Shared SGA definitions: direction encoding, button indices and the reversal rule.
// The datapath head-movement logic imports this same package.
package sga_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_RIGHT = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b01;
    localparam dir_t DIR_UP    = 2'b10;
    localparam dir_t DIR_DOWN  = 2'b11;

    localparam int NUM_BUTTONS = 4;
    localparam int BTN_RIGHT   = 0;
    localparam int BTN_LEFT    = 1;
    localparam int BTN_UP      = 2;
    localparam int BTN_DOWN    = 3;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } dir_pick_t;

    // Opposite directions share the axis bit and differ only in the sign bit.
    function automatic logic is_reversal(dir_t cand, dir_t ref_dir);
        return (cand[1] == ref_dir[1]) && (cand[0] != ref_dir[0]);
    endfunction

    // Fixed priority when several buttons rise together: up > down > left > right.
    function automatic dir_pick_t pick_direction(logic [NUM_BUTTONS-1:0] rise);
        dir_pick_t p;
        p.valid = |rise;
        p.dir   = DIR_RIGHT;
        if (rise[BTN_UP]) begin
            p.dir = DIR_UP;
        end else if (rise[BTN_DOWN]) begin
            p.dir = DIR_DOWN;
        end else if (rise[BTN_LEFT]) begin
            p.dir = DIR_LEFT;
        end else if (rise[BTN_RIGHT]) begin
            p.dir = DIR_RIGHT;
        end
        return p;
    endfunction

endpackage

// File: rtl/sga_debouncer.sv
// One-button input conditioner: 2-flop synchronizer followed by a stability counter.
// The clean level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module sga_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    if ((DEBOUNCE_CYCLES < 2) ||
        ((CNT_W < 32) && ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)))) begin : g_param_err
        $error("sga_debouncer: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clean_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            if (sync_q[1] != clean_q) begin
                if (cnt_q == CNT_LAST) begin
                    clean_q <= ~clean_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                // Any return to the clean level restarts the stability window.
                cnt_q <= '0;
            end
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/sga_direction_unit.sv
// SGA input stage: debounces the direction buttons, filters 180-degree reversals and
// holds the newest legal request until the datapath move tick commits it.
module sga_direction_unit
    import sga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   enable,
    input  logic                   clear_direction,
    input  logic                   move_tick,
    output logic [1:0]             direction,
    output logic [1:0]             pending,
    output logic                   any_press,
    output logic [NUM_BUTTONS-1:0] db_buttons_clean
);

    logic [NUM_BUTTONS-1:0] clean;
    logic [NUM_BUTTONS-1:0] clean_d;
    logic [NUM_BUTTONS-1:0] rise;
    dir_pick_t              pick;
    dir_t                   ref_dir;
    logic                   accept;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_db
        sga_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clock(clock),
            .reset(reset),
            .raw  (buttons[i]),
            .clean(clean[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            clean_d <= '0;
            rise    <= '0;
        end else begin
            clean_d <= clean;
            rise    <= clean & ~clean_d;
        end
    end

    assign any_press        = |rise;
    assign db_buttons_clean = clean;

    // Requests are judged against the direction in force after this cycle's commit,
    // so a press coinciding with the tick is checked against the outgoing pending.
    assign pick    = pick_direction(rise);
    assign ref_dir = move_tick ? pending : direction;
    assign accept  = enable && pick.valid &&
                     !is_reversal(pick.dir, ref_dir) && (pick.dir != ref_dir);

    always_ff @(posedge clock) begin
        if (reset) begin
            direction <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
        end else if (clear_direction) begin
            direction <= DIR_RIGHT;
            pending   <= DIR_RIGHT;
        end else begin
            // The commit ignores enable so a paused game still tracks its last request.
            if (move_tick) begin
                direction <= pending;
            end
            if (accept) begin
                pending <= pick.dir;
            end
        end
    end

endmodule

// File: tb/tb_sga_direction_unit.sv
// Self-checking bench for sga_direction_unit with a short debounce window.
// A history-window model of the button conditioning and a direction model run in lockstep.
module tb_sga_direction_unit;

    localparam int DC = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] buttons = 4'b0000;
    logic       enable = 1'b0;
    logic       clear_direction = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] direction;
    logic [1:0] pending;
    logic       any_press;
    logic [3:0] db_buttons_clean;

    always #5 clock = ~clock;

    sga_direction_unit #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_W          (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .buttons         (buttons),
        .enable          (enable),
        .clear_direction (clear_direction),
        .move_tick       (move_tick),
        .direction       (direction),
        .pending         (pending),
        .any_press       (any_press),
        .db_buttons_clean(db_buttons_clean)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: raw samples per button, debounced levels, edge pulses, directions.
    bit         m_hist[4][$];
    logic [3:0] m_clean = 4'b0000;
    logic [3:0] m_clean_prev = 4'b0000;
    logic [3:0] m_rise = 4'b0000;
    logic [1:0] m_dir = 2'b00;
    logic [1:0] m_pend = 2'b00;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // Advance one clock: compute the model's next state from the inputs now applied,
    // take the edge, then settle 1 ns past it.
    task automatic step();
        logic [3:0] n_clean;
        logic [3:0] n_rise;
        logic [1:0] n_dir;
        logic [1:0] n_pend;
        logic [1:0] cand;
        logic [1:0] refd;
        bit         rst;
        bit         diff;
        rst     = reset;
        n_clean = m_clean;
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                m_hist[i].delete();
                for (int k = 0; k < DC + 2; k++) m_hist[i].push_back(1'b0);
                n_clean[i] = 1'b0;
            end else begin
                m_hist[i].push_back(buttons[i]);
                // A level is accepted once the last DC synchronized samples all disagree.
                diff = 1'b1;
                for (int k = 2; k <= DC + 1; k++)
                    if (m_hist[i][m_hist[i].size() - 1 - k] == m_clean[i]) diff = 1'b0;
                if (diff) n_clean[i] = ~m_clean[i];
                if (m_hist[i].size() > DC + 4) void'(m_hist[i].pop_front());
            end
        end
        n_rise = rst ? 4'b0000 : (m_clean & ~m_clean_prev);
        n_dir  = m_dir;
        n_pend = m_pend;
        cand   = 2'b00;
        if (rst || clear_direction) begin
            n_dir  = 2'b00;
            n_pend = 2'b00;
        end else begin
            refd = move_tick ? m_pend : m_dir;
            if (move_tick) n_dir = m_pend;
            if (enable && (m_rise != 4'b0000)) begin
                if (m_rise[2])      cand = 2'b10;
                else if (m_rise[3]) cand = 2'b11;
                else if (m_rise[1]) cand = 2'b01;
                else                cand = 2'b00;
                if ((cand != opposite(refd)) && (cand != refd)) n_pend = cand;
            end
        end
        @(posedge clock);
        m_clean_prev = rst ? 4'b0000 : m_clean;
        m_clean      = n_clean;
        m_rise       = n_rise;
        m_dir        = n_dir;
        m_pend       = n_pend;
        #1;
    endtask

    task automatic press(input logic [3:0] mask);
        buttons = mask;
        repeat (DC + 5) step();
        buttons = 4'b0000;
        repeat (DC + 5) step();
    endtask

    task automatic clear_pulse();
        clear_direction = 1'b1;
        step();
        clear_direction = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL reset_direction got=%b exp=00", direction); end
        n_cmp++; if (pending !== 2'b00) begin n_err++; $display("FAIL reset_pending got=%b exp=00", pending); end
        n_cmp++; if (any_press !== 1'b0) begin n_err++; $display("FAIL reset_any_press got=%b exp=0", any_press); end
        n_cmp++; if (db_buttons_clean !== 4'b0000) begin n_err++; $display("FAIL reset_clean got=%b exp=0000", db_buttons_clean); end
    endtask

    task automatic test_up_press();
        int pulses;
        enable  = 1'b1;
        buttons = 4'b0100;
        pulses  = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (any_press === 1'b1) pulses++;
            if (c == 5) begin
                n_cmp++; if (db_buttons_clean !== 4'b0000) begin n_err++; $display("FAIL up_clean_early got=%b exp=0000", db_buttons_clean); end
            end
            if (c == 6) begin
                n_cmp++; if (db_buttons_clean !== 4'b0100) begin n_err++; $display("FAIL up_clean_latency got=%b exp=0100", db_buttons_clean); end
            end
            if (c == 7) begin
                n_cmp++; if (any_press !== 1'b1) begin n_err++; $display("FAIL up_any_press got=%b exp=1", any_press); end
            end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL up_press_count got=%0d exp=1", pulses); end
        n_cmp++; if (pending !== 2'b10) begin n_err++; $display("FAIL up_pending got=%b exp=10", pending); end
        n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL up_dir_before_tick got=%b exp=00", direction); end
        buttons = 4'b0000;
        repeat (DC + 5) step();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        n_cmp++; if (direction !== 2'b10) begin n_err++; $display("FAIL up_dir_after_tick got=%b exp=10", direction); end
    endtask

    task automatic test_glitch();
        int bad;
        bad     = 0;
        buttons = 4'b1000;
        repeat (DC - 1) begin
            step();
            if ((db_buttons_clean !== 4'b0000) || (any_press !== 1'b0)) bad++;
        end
        buttons = 4'b0000;
        repeat (DC + 6) begin
            step();
            if ((db_buttons_clean !== 4'b0000) || (any_press !== 1'b0)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_err++; $display("FAIL glitch_visible got=%0d cycles exp=0", bad); end
        n_cmp++; if (pending !== 2'b10) begin n_err++; $display("FAIL glitch_pending got=%b exp=10", pending); end
    endtask

    task automatic test_reversal();
        clear_pulse();
        n_cmp++; if ({direction, pending} !== 4'b0000) begin n_err++; $display("FAIL clear_state got=%b exp=0000", {direction, pending}); end
        press(4'b0010);
        n_cmp++; if (pending !== 2'b00) begin n_err++; $display("FAIL reversal_left got=%b exp=00", pending); end
        press(4'b0100);
        n_cmp++; if (pending !== 2'b10) begin n_err++; $display("FAIL reversal_then_up got=%b exp=10", pending); end
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        n_cmp++; if (direction !== 2'b10) begin n_err++; $display("FAIL reversal_commit got=%b exp=10", direction); end
    endtask

    task automatic test_priority();
        clear_pulse();
        press(4'b0110);
        n_cmp++; if (pending !== 2'b10) begin n_err++; $display("FAIL priority_up_left got=%b exp=10", pending); end
        n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL priority_dir got=%b exp=00", direction); end
    endtask

    task automatic test_tick_collision();
        clear_pulse();
        press(4'b0100);
        buttons = 4'b1000;
        repeat (DC + 3) step();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        n_cmp++; if (direction !== 2'b10) begin n_err++; $display("FAIL collide_down_dir got=%b exp=10", direction); end
        n_cmp++; if (pending !== 2'b10) begin n_err++; $display("FAIL collide_down_pending got=%b exp=10", pending); end
        buttons = 4'b0000;
        repeat (DC + 5) step();
        buttons = 4'b0010;
        repeat (DC + 3) step();
        move_tick = 1'b1;
        step();
        move_tick = 1'b0;
        n_cmp++; if (pending !== 2'b01) begin n_err++; $display("FAIL collide_left_pending got=%b exp=01", pending); end
        n_cmp++; if (direction !== 2'b10) begin n_err++; $display("FAIL collide_left_dir got=%b exp=10", direction); end
        buttons = 4'b0000;
        repeat (DC + 5) step();
    endtask

    task automatic test_back_to_back();
        clear_pulse();
        press(4'b0100);
        press(4'b1000);
        n_cmp++; if (pending !== 2'b11) begin n_err++; $display("FAIL last_wins_pending got=%b exp=11", pending); end
        n_cmp++; if (direction !== 2'b00) begin n_err++; $display("FAIL last_wins_dir got=%b exp=00", direction); end
    endtask

    task automatic test_enable_off();
        int   pulses;
        logic [1:0] pend_before;
        pend_before = pending;
        enable  = 1'b0;
        buttons = 4'b0100;
        pulses  = 0;
        repeat (DC + 5) begin
            step();
            if (any_press === 1'b1) pulses++;
        end
        buttons = 4'b0000;
        repeat (DC + 5) step();
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL disabled_any_press got=%0d exp=1", pulses); end
        n_cmp++; if (pending !== 2'b11) begin n_err++; $display("FAIL disabled_pending got=%b exp=11 (was %b)", pending, pend_before); end
        clear_direction = 1'b1;
        move_tick       = 1'b1;
        step();
        clear_direction = 1'b0;
        move_tick       = 1'b0;
        n_cmp++; if ({direction, pending} !== 4'b0000) begin n_err++; $display("FAIL clear_with_tick got=%b exp=0000", {direction, pending}); end
        enable = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(5, 0) == 0) buttons[i] = ~buttons[i];
            move_tick       = ($urandom_range(9, 0) == 0);
            clear_direction = ($urandom_range(199, 0) == 0);
            enable          = ($urandom_range(99, 0) < 85);
            reset           = ($urandom_range(599, 0) == 0);
            step();
            n_cmp++; if (db_buttons_clean !== m_clean) begin n_err++; $display("FAIL rand_clean cyc=%0d got=%b exp=%b", c, db_buttons_clean, m_clean); end
            n_cmp++; if (any_press !== (|m_rise)) begin n_err++; $display("FAIL rand_any_press cyc=%0d got=%b exp=%b", c, any_press, |m_rise); end
            n_cmp++; if (direction !== m_dir) begin n_err++; $display("FAIL rand_direction cyc=%0d got=%b exp=%b", c, direction, m_dir); end
            n_cmp++; if (pending !== m_pend) begin n_err++; $display("FAIL rand_pending cyc=%0d got=%b exp=%b", c, pending, m_pend); end
        end
        reset           = 1'b0;
        move_tick       = 1'b0;
        clear_direction = 1'b0;
        buttons         = 4'b0000;
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < DC + 2; k++) m_hist[i].push_back(1'b0);
        test_reset();
        test_up_press();
        test_glitch();
        test_reversal();
        test_priority();
        test_tick_collision();
        test_back_to_back();
        test_enable_off();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sga_direction_unit.md
Name: sga_direction_unit

Overview:
- Input stage directly upstream of the SGA datapath (SGA_FD) and control unit (SGA_UC).
- Synchronizes and debounces the four raw direction buttons, then rising-edge-detects them.
- Rejects 180° reversals and holds the newest legal request as a pending direction.
- Commits the pending direction to the snake's movement direction only on the datapath's move tick. Also emits a generic press pulse that the UC may use to leave idle.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a debounced button changes (1 ms at 50 MHz); must be ≥ 2.
- CNT_W, 16, counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- buttons  in  4  raw asynchronous buttons, active-high: [0]=right, [1]=left, [2]=up, [3]=down.
- enable  in  1  game running (not paused/finished); gates acceptance of requests.
- clear_direction  in  1  UC restart-of-play strobe; forces initial direction.
- move_tick  in  1  one-cycle pulse from datapath step timer; commit point.
- direction  out  2  committed direction: 00 right, 01 left, 10 up, 11 down.
- pending  out  2  next direction to be committed.
- any_press  out  1  one-cycle pulse on any debounced rising edge, regardless of enable.
- db_buttons_clean  out  4  debounced button levels.

Behaviour:
- Reset (synchronous, active-high) clears sync flops, debounce counters and clean levels. direction=00, pending=00, any_press=0, db_buttons_clean=0000.
- Per-button 2-flop synchronizer, then debouncer:
  - If the synced level ≠ clean level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still different, clean toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
  - Latency from raw edge to clean edge is 2 + DEBOUNCE_CYCLES cycles.
- Rising edge: rise[i] = clean[i] & ~clean_d[i], registered. any_press = |rise, a one-cycle pulse.
- Selection when several rise in the same cycle: fixed priority up > down > left > right. Exactly one candidate is produced.
- Reversal rule: a candidate c is legal iff NOT (c[1]==ref[1] and c[0]!=ref[0]). ref is the direction after this cycle's commit: pending if move_tick=1, otherwise direction.
- Pending update:
  - Applies only if enable=1 and the candidate is legal.
  - The pending value is overwritten by later legal presses before the tick; the last one wins.
  - A candidate equal to ref is legal but changes nothing.
- Commit: on move_tick=1, direction <= pending (always, even with enable=0, so a paused game stays consistent).
- Same-cycle move_tick and press:
  - direction <= old pending.
  - The press is checked against old pending.
  - If legal, the press becomes the new pending.
- clear_direction=1 has the highest priority below reset: direction=00, pending=00, and that cycle's press and tick are ignored. Debounce state is unaffected.
- enable=0: presses still update clean levels and any_press, but pending does not change.
- Held buttons do not repeat; a new press requires release plus re-press.
- Reset or clear mid-debounce: reset restarts the counter; clear leaves it running.

Decomposition:
- Shared package sga_pkg holds:
  - Direction constants DIR_RIGHT=2'b00, DIR_LEFT=2'b01, DIR_UP=2'b10, DIR_DOWN=2'b11.
  - Button index constants.
  - The is_reversal function. The datapath's head-movement logic reuses the same package.
- One natural sub-module: sga_debouncer (synchronizer plus counter, one button, DEBOUNCE_CYCLES/CNT_W parameters), instantiated 4×. Selection, reversal check and pending/direction registers live in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then hold up 10 cycles with enable=1 → db_buttons_clean=0100 at cycle 6 after the edge. any_press pulses once, pending=10, direction stays 00 until move_tick, then 10.
- 3-cycle glitch on down → clean never changes, no any_press, pending unchanged.
- direction=00 (right), press left with enable=1 → pending stays 00. Then press up → pending=10. Tick → direction=10.
- Up and left rise in the same cycle with direction=00 → pending=10 (up wins).
- pending=10, direction=00: press down in the same cycle as move_tick → direction=10, pending stays 10 (down is a reversal of up). Repeat with left → pending=01.
- enable=0, press up → any_press=1, pending unchanged. Then clear_direction during a tick → direction=00, pending=00.
